// File: rtl/cpu_dma_queue_stat_regs_if.sv
// rtl/cpu_dma_queue_stat_regs_if.sv - register access bus for the CPU DMA queue statistics block
interface cpu_dma_queue_stat_regs_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  reg_req;
  logic                  reg_rd_wr_L;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [31:0]           reg_wr_data;
  logic [31:0]           reg_rd_data;
  logic                  reg_ack;

  modport master (
    output reg_req, reg_rd_wr_L, reg_addr, reg_wr_data,
    input  reg_rd_data, reg_ack
  );

  modport slave (
    input  reg_req, reg_rd_wr_L, reg_addr, reg_wr_data,
    output reg_rd_data, reg_ack
  );
endinterface

// File: rtl/cpu_dma_queue_stat_regs.sv
// rtl/cpu_dma_queue_stat_regs.sv - per-queue control, sticky status and event counters for CPU DMA queues
module cpu_dma_queue_stat_regs #(
  parameter int NUM_QUEUES = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int SATURATE   = 1,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  cpu_dma_queue_stat_regs_if.slave bus,
  output logic [NUM_QUEUES-1:0]   rx_queue_en,
  output logic [NUM_QUEUES-1:0]   tx_queue_en,
  input  logic [NUM_QUEUES-1:0]   rx_pkt_stored,
  input  logic [NUM_QUEUES-1:0]   rx_pkt_removed,
  input  logic [NUM_QUEUES-1:0]   rx_pkt_dropped,
  input  logic [NUM_QUEUES-1:0]   rx_q_overrun,
  input  logic [NUM_QUEUES-1:0]   rx_q_underrun,
  input  logic [NUM_QUEUES-1:0]   tx_pkt_stored,
  input  logic [NUM_QUEUES-1:0]   tx_pkt_removed,
  input  logic [NUM_QUEUES-1:0]   tx_q_overrun,
  input  logic [NUM_QUEUES-1:0]   tx_q_underrun,
  input  logic [12*NUM_QUEUES-1:0] rx_pkt_byte_cnt,
  input  logic [12*NUM_QUEUES-1:0] tx_pkt_byte_cnt
);

  localparam int          QW      = ADDR_WIDTH - 3;
  localparam int          NCNT    = 6;
  localparam logic [32:0] CNT_MAX = (33'd1 << CNT_WIDTH) - 33'd1;

  // Counter slot k lives at register offset k+2.
  logic [CNT_WIDTH-1:0] cnt    [NUM_QUEUES][NCNT];
  logic [1:0]           ctrl   [NUM_QUEUES];
  logic [3:0]           status [NUM_QUEUES];

  logic [NCNT-1:0]      ev     [NUM_QUEUES];
  logic [11:0]          ev_inc [NUM_QUEUES][NCNT];
  logic [3:0]           st_set [NUM_QUEUES];

  logic          req_d;
  logic          new_req;
  logic          is_wr;
  logic [2:0]    offset;
  logic [QW-1:0] qidx;
  logic          addr_ok;
  logic [31:0]   rd_val;
  logic          unused_wr_bits;

  assign offset         = bus.reg_addr[2:0];
  assign qidx           = bus.reg_addr[ADDR_WIDTH-1:3];
  assign new_req        = bus.reg_req & ~req_d;
  assign is_wr          = new_req & ~bus.reg_rd_wr_L & addr_ok;
  assign unused_wr_bits = ^bus.reg_wr_data;

  function automatic logic [CNT_WIDTH-1:0] cnt_add(input logic [CNT_WIDTH-1:0] cur,
                                                   input logic [11:0]          inc);
    logic [32:0] sum;
    sum = 33'(cur) + 33'(inc);
    if (sum > CNT_MAX)
      cnt_add = (SATURATE != 0) ? CNT_MAX[CNT_WIDTH-1:0] : sum[CNT_WIDTH-1:0];
    else
      cnt_add = sum[CNT_WIDTH-1:0];
  endfunction

  // Whole upper address field is compared, so stray high bits never alias a queue.
  always_comb begin
    addr_ok = 1'b0;
    for (int q = 0; q < NUM_QUEUES; q++)
      if (qidx == QW'(q)) addr_ok = 1'b1;
  end

  always_comb begin
    for (int q = 0; q < NUM_QUEUES; q++) begin
      ev[q] = {tx_pkt_removed[q], tx_pkt_stored[q], rx_pkt_stored[q],
               rx_pkt_removed[q], rx_pkt_dropped[q], rx_pkt_stored[q]};
      for (int k = 0; k < NCNT; k++) ev_inc[q][k] = 12'd1;
      ev_inc[q][3] = rx_pkt_byte_cnt[12*q +: 12];
      ev_inc[q][5] = tx_pkt_byte_cnt[12*q +: 12];
      st_set[q] = {tx_q_underrun[q], tx_q_overrun[q], rx_q_underrun[q], rx_q_overrun[q]};
    end
  end

  always_comb begin
    rd_val = 32'hDEAD_BEEF;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (qidx == QW'(q)) begin
        case (offset)
          3'd0:    rd_val = {30'd0, ctrl[q]};
          3'd1:    rd_val = {28'd0, status[q]};
          3'd2:    rd_val = 32'(cnt[q][0]);
          3'd3:    rd_val = 32'(cnt[q][1]);
          3'd4:    rd_val = 32'(cnt[q][2]);
          3'd5:    rd_val = 32'(cnt[q][3]);
          3'd6:    rd_val = 32'(cnt[q][4]);
          default: rd_val = 32'(cnt[q][5]);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_d           <= 1'b0;
      bus.reg_ack     <= 1'b0;
      bus.reg_rd_data <= 32'd0;
    end else begin
      req_d       <= bus.reg_req;
      bus.reg_ack <= new_req;
      if (new_req && bus.reg_rd_wr_L)
        bus.reg_rd_data <= rd_val;
    end
  end

  // A write to a counter in the same cycle as its event overrides the event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        ctrl[q]   <= 2'd0;
        status[q] <= 4'd0;
        for (int k = 0; k < NCNT; k++) cnt[q][k] <= '0;
      end
    end else begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (is_wr && qidx == QW'(q) && offset == 3'd0)
          ctrl[q] <= bus.reg_wr_data[1:0];
        if (is_wr && qidx == QW'(q) && offset == 3'd1)
          status[q] <= (status[q] & ~bus.reg_wr_data[3:0]) | st_set[q];
        else
          status[q] <= status[q] | st_set[q];
        for (int k = 0; k < NCNT; k++) begin
          if (is_wr && qidx == QW'(q) && offset == 3'(k + 2))
            cnt[q][k] <= bus.reg_wr_data[CNT_WIDTH-1:0];
          else if (ev[q][k])
            cnt[q][k] <= cnt_add(cnt[q][k], ev_inc[q][k]);
        end
      end
    end
  end

  always_comb begin
    for (int q = 0; q < NUM_QUEUES; q++) begin
      rx_queue_en[q] = ~ctrl[q][0];
      tx_queue_en[q] = ~ctrl[q][1];
    end
  end

endmodule

// File: tb/tb_cpu_dma_queue_stat_regs.sv
// tb/tb_cpu_dma_queue_stat_regs.sv - bench for cpu_dma_queue_stat_regs across three counter configurations
module tb_cpu_dma_queue_stat_regs;
  localparam int NQ = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        req = 1'b0, rd = 1'b1;
  logic [5:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [NQ-1:0] rx_st = '0, rx_rm = '0, rx_dr = '0, rx_ov = '0, rx_un = '0;
  logic [NQ-1:0] tx_st = '0, tx_rm = '0, tx_ov = '0, tx_un = '0;
  logic [12*NQ-1:0] rx_b = '0, tx_b = '0;

  cpu_dma_queue_stat_regs_if #(.ADDR_WIDTH(6)) if_a ();
  cpu_dma_queue_stat_regs_if #(.ADDR_WIDTH(6)) if_b ();
  cpu_dma_queue_stat_regs_if #(.ADDR_WIDTH(6)) if_c ();
  assign if_a.reg_req = req; assign if_a.reg_rd_wr_L = rd; assign if_a.reg_addr = addr; assign if_a.reg_wr_data = wdata;
  assign if_b.reg_req = req; assign if_b.reg_rd_wr_L = rd; assign if_b.reg_addr = addr; assign if_b.reg_wr_data = wdata;
  assign if_c.reg_req = req; assign if_c.reg_rd_wr_L = rd; assign if_c.reg_addr = addr; assign if_c.reg_wr_data = wdata;

  logic [NQ-1:0] rxen_w [3];
  logic [NQ-1:0] txen_w [3];
  logic [31:0]   rd_w   [3];
  logic          ack_w  [3];
  assign rd_w[0] = if_a.reg_rd_data; assign ack_w[0] = if_a.reg_ack;
  assign rd_w[1] = if_b.reg_rd_data; assign ack_w[1] = if_b.reg_ack;
  assign rd_w[2] = if_c.reg_rd_data; assign ack_w[2] = if_c.reg_ack;

  cpu_dma_queue_stat_regs #(.NUM_QUEUES(NQ), .CNT_WIDTH(32), .SATURATE(1), .ADDR_WIDTH(6)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave), .rx_queue_en(rxen_w[0]), .tx_queue_en(txen_w[0]),
    .rx_pkt_stored(rx_st), .rx_pkt_removed(rx_rm), .rx_pkt_dropped(rx_dr), .rx_q_overrun(rx_ov),
    .rx_q_underrun(rx_un), .tx_pkt_stored(tx_st), .tx_pkt_removed(tx_rm), .tx_q_overrun(tx_ov),
    .tx_q_underrun(tx_un), .rx_pkt_byte_cnt(rx_b), .tx_pkt_byte_cnt(tx_b));
  cpu_dma_queue_stat_regs #(.NUM_QUEUES(NQ), .CNT_WIDTH(8), .SATURATE(1), .ADDR_WIDTH(6)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave), .rx_queue_en(rxen_w[1]), .tx_queue_en(txen_w[1]),
    .rx_pkt_stored(rx_st), .rx_pkt_removed(rx_rm), .rx_pkt_dropped(rx_dr), .rx_q_overrun(rx_ov),
    .rx_q_underrun(rx_un), .tx_pkt_stored(tx_st), .tx_pkt_removed(tx_rm), .tx_q_overrun(tx_ov),
    .tx_q_underrun(tx_un), .rx_pkt_byte_cnt(rx_b), .tx_pkt_byte_cnt(tx_b));
  cpu_dma_queue_stat_regs #(.NUM_QUEUES(NQ), .CNT_WIDTH(8), .SATURATE(0), .ADDR_WIDTH(6)) dut_c (
    .clk(clk), .reset(reset), .bus(if_c.slave), .rx_queue_en(rxen_w[2]), .tx_queue_en(txen_w[2]),
    .rx_pkt_stored(rx_st), .rx_pkt_removed(rx_rm), .rx_pkt_dropped(rx_dr), .rx_q_overrun(rx_ov),
    .rx_q_underrun(rx_un), .tx_pkt_stored(tx_st), .tx_pkt_removed(tx_rm), .tx_q_overrun(tx_ov),
    .tx_q_underrun(tx_un), .rx_pkt_byte_cnt(rx_b), .tx_pkt_byte_cnt(tx_b));

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cfg%0d: actual %h required %h at %0t", name, c, act, exp, $time);
    end
  endtask

  // Model: counters as plain integers, bounded per configuration only when updated.
  int     cw  [3] = '{32, 8, 8};
  bit     sat [3] = '{1'b1, 1'b1, 1'b0};
  longint mcnt [3][NQ][6];
  logic [1:0]  mctrl [NQ];
  logic [3:0]  mstat [NQ];
  logic [31:0] exp_rd [3];
  bit          exp_ack;
  bit          mprev;

  function automatic longint mmask(input int c);
    return (longint'(1) << cw[c]) - 1;
  endfunction

  function automatic longint madd(input int c, input longint cur, input longint inc);
    longint s;
    s = cur + inc;
    if (s > mmask(c)) return sat[c] ? mmask(c) : (s & mmask(c));
    return s;
  endfunction

  function automatic logic [31:0] mread(input int c, input logic [5:0] a);
    int q, off;
    q = int'(a) / 8;
    off = int'(a) % 8;
    if (q >= NQ) return 32'hDEAD_BEEF;
    if (off == 0) return {30'd0, mctrl[q]};
    if (off == 1) return {28'd0, mstat[q]};
    return 32'(mcnt[c][q][off-2]);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < 3; c++) begin
        exp_rd[c] = 32'd0;
        for (int q = 0; q < NQ; q++) for (int k = 0; k < 6; k++) mcnt[c][q][k] = 0;
      end
      for (int q = 0; q < NQ; q++) begin mctrl[q] = 2'd0; mstat[q] = 4'd0; end
      exp_ack = 1'b0;
      mprev = 1'b0;
    end else begin
      bit nr;
      int wq, woff;
      nr = req && !mprev;
      mprev = req;
      exp_ack = nr;
      wq = int'(addr) / 8;
      woff = int'(addr) % 8;
      if (nr && rd) for (int c = 0; c < 3; c++) exp_rd[c] = mread(c, addr);
      for (int q = 0; q < NQ; q++) begin
        logic [3:0] clr;
        for (int c = 0; c < 3; c++) begin
          if (rx_st[q]) mcnt[c][q][0] = madd(c, mcnt[c][q][0], 1);
          if (rx_dr[q]) mcnt[c][q][1] = madd(c, mcnt[c][q][1], 1);
          if (rx_rm[q]) mcnt[c][q][2] = madd(c, mcnt[c][q][2], 1);
          if (rx_st[q]) mcnt[c][q][3] = madd(c, mcnt[c][q][3], longint'(rx_b[12*q +: 12]));
          if (tx_st[q]) mcnt[c][q][4] = madd(c, mcnt[c][q][4], 1);
          if (tx_rm[q]) mcnt[c][q][5] = madd(c, mcnt[c][q][5], longint'(tx_b[12*q +: 12]));
          if (nr && !rd && wq == q && woff >= 2)
            mcnt[c][q][woff-2] = longint'(wdata) & mmask(c);
        end
        clr = (nr && !rd && wq == q && woff == 1) ? wdata[3:0] : 4'd0;
        mstat[q] = (mstat[q] & ~clr) | {tx_un[q], tx_ov[q], rx_un[q], rx_ov[q]};
        if (nr && !rd && wq == q && woff == 0) mctrl[q] = wdata[1:0];
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [NQ-1:0] erx, etx;
      for (int q = 0; q < NQ; q++) begin erx[q] = ~mctrl[q][0]; etx[q] = ~mctrl[q][1]; end
      for (int c = 0; c < 3; c++) begin
        chk("ack", c, {31'd0, ack_w[c]}, {31'd0, exp_ack});
        chk("rd_data", c, rd_w[c], exp_rd[c]);
        chk("rx_queue_en", c, {28'd0, rxen_w[c]}, {28'd0, erx});
        chk("tx_queue_en", c, {28'd0, txen_w[c]}, {28'd0, etx});
      end
    end
  end

  logic [31:0] d0, d1, d2;

  task automatic do_access(input logic rnw, input logic [5:0] a, input logic [31:0] wd);
    @(negedge clk);
    req = 1'b1; rd = rnw; addr = a; wdata = wd;
    @(negedge clk);
    d0 = rd_w[0]; d1 = rd_w[1]; d2 = rd_w[2];
    req = 1'b0;
  endtask

  initial begin
    int acks;
    repeat (2) @(negedge clk);
    started = 1'b1;
    for (int c = 0; c < 3; c++) chk("reset_rx_en_lit", c, {28'd0, rxen_w[c]}, 32'hF);
    chk("reset_rd_lit", 0, rd_w[0], 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // 300 consecutive rx stores on queue 0, 10 bytes each
    rx_b[11:0] = 12'd10;
    for (int i = 0; i < 300; i++) begin @(negedge clk); rx_st = 4'b0001; end
    @(negedge clk); rx_st = '0;
    do_access(1'b1, 6'd2, 32'd0);
    chk("rx_pkts_300_lit", 0, d0, 32'h0000_012C);
    chk("rx_pkts_300_lit", 1, d1, 32'h0000_00FF);
    chk("rx_pkts_300_lit", 2, d2, 32'h0000_002C);
    do_access(1'b1, 6'd5, 32'd0);
    chk("rx_bytes_lit", 0, d0, 32'h0000_0BB8);

    // tx byte accumulation across the 12-bit boundary on queue 3
    @(negedge clk); tx_rm = 4'b1000; tx_b[47:36] = 12'hFFF;
    @(negedge clk); tx_b[47:36] = 12'h001;
    @(negedge clk); tx_rm = '0;
    do_access(1'b1, {3'd3, 3'd7}, 32'd0);
    chk("tx_bytes_lit", 0, d0, 32'h0000_1000);
    chk("tx_bytes_lit", 1, d1, 32'h0000_00FF);
    do_access(1'b1, {3'd3, 3'd6}, 32'd0);
    chk("tx_pkts_lit", 0, d0, 32'd0);

    // control disable bits on queue 2
    do_access(1'b0, {3'd2, 3'd0}, 32'hFFFF_FFFF);
    do_access(1'b1, {3'd2, 3'd0}, 32'd0);
    chk("ctrl_rd_lit", 0, d0, 32'h0000_0003);
    chk("rx_en_lit", 0, {28'd0, rxen_w[0]}, 32'hB);
    chk("tx_en_lit", 0, {28'd0, txen_w[0]}, 32'hB);

    // out-of-range queue with request held for 10 cycles
    acks = 0;
    @(negedge clk); req = 1'b1; rd = 1'b1; addr = {3'd5, 3'd0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack_w[0]) begin acks++; d0 = rd_w[0]; end
    end
    req = 1'b0;
    chk("held_req_acks_lit", 0, 32'(acks), 32'd1);
    chk("bad_queue_lit", 0, d0, 32'hDEAD_BEEF);

    // counter write collides with its event: write wins
    @(negedge clk); rx_st = 4'b0001; req = 1'b1; rd = 1'b0; addr = 6'd2; wdata = 32'h0000_0155;
    @(negedge clk); rx_st = '0; req = 1'b0;
    do_access(1'b1, 6'd2, 32'd0);
    chk("wr_wins_lit", 0, d0, 32'h0000_0155);
    chk("wr_wins_lit", 1, d1, 32'h0000_0055);

    // sticky status set and cleared in the same cycle on queue 1
    @(negedge clk); rx_ov = 4'b0010; req = 1'b1; rd = 1'b0; addr = {3'd1, 3'd1}; wdata = 32'h1;
    @(negedge clk); rx_ov = '0; req = 1'b0;
    do_access(1'b1, {3'd1, 3'd1}, 32'd0);
    chk("status_set_lit", 0, d0, 32'h1);
    do_access(1'b0, {3'd1, 3'd1}, 32'h1);
    do_access(1'b1, {3'd1, 3'd1}, 32'd0);
    chk("status_clr_lit", 0, d0, 32'h0);

    // mixed events on all queues with interleaved accesses
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      rx_st = 4'($urandom); rx_rm = 4'($urandom); rx_dr = 4'($urandom);
      rx_ov = 4'($urandom_range(0, 15) == 0 ? 1 : 0); rx_un = 4'($urandom_range(0, 15) == 0 ? 2 : 0);
      tx_st = 4'($urandom); tx_rm = 4'($urandom);
      tx_ov = 4'($urandom_range(0, 15) == 0 ? 4 : 0); tx_un = 4'($urandom_range(0, 15) == 0 ? 8 : 0);
      rx_b = {$urandom, $urandom}; tx_b = {$urandom, $urandom};
      req = (i % 3 == 0); rd = (i % 12 != 6); addr = 6'($urandom); wdata = $urandom;
    end
    @(negedge clk);
    {rx_st, rx_rm, rx_dr, rx_ov, rx_un, tx_st, tx_rm, tx_ov, tx_un} = '0;
    req = 1'b0;
    for (int a = 0; a < 64; a++) do_access(1'b1, 6'(a), 32'd0);

    // reset pulse during a read and during counting
    @(negedge clk); req = 1'b1; rd = 1'b1; addr = 6'd2; rx_st = 4'hF;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ack_lit", 0, {31'd0, ack_w[0]}, 32'd0);
    @(negedge clk);
    chk("reset_en_lit", 0, {28'd0, rxen_w[0] & txen_w[0]}, 32'hF);
    rx_st = '0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_ack_lit", 0, {31'd0, ack_w[0]}, 32'd1);
    chk("post_reset_rd_lit", 0, rd_w[0], 32'd0);
    req = 1'b0;
    for (int a = 0; a < 32; a++) do_access(1'b1, 6'(a), 32'd0);
    do_access(1'b1, {3'd2, 3'd0}, 32'd0);
    chk("reset_ctrl_lit", 0, d0, 32'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
